// File: rtl/calc_pkg.sv
// Shared definitions for the calculator execution core.
package calc_pkg;

  localparam int unsigned CMD_W      = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TAG_W      = 2;
  localparam int unsigned RESP_W     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SHAMT_W    = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } resp_t;

endpackage

// File: rtl/calc_resp_fifo.sv
// Response queue: up to two writes and one read per cycle.
// Port 0 is stored ahead of port 1 when both write together.
module calc_resp_fifo
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  wr0_valid_i,
  input  resp_t wr0_data_i,
  input  logic  wr1_valid_i,
  input  resp_t wr1_data_i,
  input  logic  pop_i,
  output resp_t head_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  resp_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;

  logic [1:0]     n_req, n_acc;
  logic [CW:0]    free_w;
  resp_t          slot0, slot1;
  logic           pop_eff, ovf;

  // Pack requests into consecutive slots and clip to the free space (pop frees one slot).
  always_comb begin
    n_req   = {1'b0, wr0_valid_i} + {1'b0, wr1_valid_i};
    slot0   = wr0_valid_i ? wr0_data_i : wr1_data_i;
    slot1   = wr1_data_i;
    pop_eff = pop_i && (count_q != '0);
    free_w  = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop_eff);
    if ({{(CW-1){1'b0}}, n_req} > free_w) n_acc = free_w[1:0];
    else                                  n_acc = n_req;
    ovf     = (n_acc != n_req);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(n_acc);
      rd_ptr_q <= rd_ptr_q + PW'(pop_eff);
      count_q  <= count_q + CW'(n_acc) - CW'(pop_eff);
    end
  end

  // Storage writes; entries are only read while counted valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (n_acc != 2'd0) mem_q[wr_ptr_q] <= slot0;
    if (n_acc == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= slot1;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !ovf);

endmodule

// File: rtl/calc_core.sv
// Calculator execution core: two-cycle command capture, single-cycle add/sub,
// iterative 1-bit/cycle shifter, responses merged through a queue.
module calc_core
  import calc_pkg::*;
#(
  parameter int unsigned CMD_WIDTH   = CMD_W,
  parameter int unsigned DATA_WIDTH  = DATA_W,
  parameter int unsigned TAG_WIDTH   = TAG_W,
  parameter int unsigned RESP_WIDTH  = RESP_W,
  parameter int unsigned FIFO_DEPTH  = calc_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic [RESP_WIDTH-1:0] out_resp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef enum logic {S_IDLE, S_OP2} state_e;

  state_e                state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  disp_q;

  logic                  shf_busy_q, shf_left_q;
  logic [SHAMT_W-1:0]    shf_cnt_q;
  logic [DATA_WIDTH-1:0] shf_val_q;
  logic [TAG_WIDTH-1:0]  shf_tag_q;
  logic                  shf_load, shf_done;

  logic                  alu_wr;
  logic [DATA_WIDTH:0]   sum;
  resp_t                 alu_ent, shf_ent, head, out_q;
  logic                  fifo_empty, fifo_full;

  // Command capture sequencing: command+op1, then op2.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_in != '0) state_d = S_OP2;
      S_OP2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Input registers; disp_q marks the cycle the captured command executes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      tag_q   <= '0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= (state_q == S_OP2);
      if (state_q == S_IDLE && cmd_in != '0) begin
        cmd_q <= cmd_in;
        op1_q <= data_in;
        tag_q <= tag_in;
      end
      if (state_q == S_OP2) op2_q <= data_in;
    end
  end

  // Execute stage: add/sub/invalid/busy-shift answer here, free shifts hand off.
  always_comb begin
    alu_wr   = 1'b0;
    alu_ent  = '0;
    shf_load = 1'b0;
    sum      = '0;
    alu_ent.tag = tag_q;
    if (disp_q) begin
      case (cmd_q)
        CMD_ADD: begin
          sum          = {1'b0, op1_q} + {1'b0, op2_q};
          alu_wr       = 1'b1;
          alu_ent.data = sum[DATA_WIDTH-1:0];
          if (sum[DATA_WIDTH]) alu_ent.resp = RESP_OVF;
          else                 alu_ent.resp = RESP_OK;
        end
        CMD_SUB: begin
          alu_wr       = 1'b1;
          alu_ent.data = op1_q - op2_q;
          if (op2_q > op1_q) alu_ent.resp = RESP_OVF;
          else               alu_ent.resp = RESP_OK;
        end
        CMD_SHL, CMD_SHR: begin
          if (shf_busy_q) begin
            alu_wr       = 1'b1;
            alu_ent.resp = RESP_INV;
          end else begin
            shf_load = 1'b1;
          end
        end
        default: begin
          alu_wr       = 1'b1;
          alu_ent.resp = RESP_INV;
        end
      endcase
    end
  end

  // Iterative shifter: one bit per cycle, answers the cycle after the count hits zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shf_busy_q <= 1'b0;
      shf_left_q <= 1'b0;
      shf_cnt_q  <= '0;
      shf_val_q  <= '0;
      shf_tag_q  <= '0;
    end else if (shf_load) begin
      shf_busy_q <= 1'b1;
      shf_left_q <= (cmd_q == CMD_SHL);
      shf_cnt_q  <= op2_q[SHAMT_W-1:0];
      shf_val_q  <= op1_q;
      shf_tag_q  <= tag_q;
    end else if (shf_busy_q) begin
      if (shf_cnt_q == '0) begin
        shf_busy_q <= 1'b0;
      end else begin
        shf_val_q <= shf_left_q ? (shf_val_q << 1) : (shf_val_q >> 1);
        shf_cnt_q <= shf_cnt_q - SHAMT_W'(1);
      end
    end
  end

  assign shf_done     = shf_busy_q && (shf_cnt_q == '0);
  assign shf_ent.resp = RESP_OK;
  assign shf_ent.data = shf_val_q;
  assign shf_ent.tag  = shf_tag_q;

  calc_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .wr0_valid_i (alu_wr),
    .wr0_data_i  (alu_ent),
    .wr1_valid_i (shf_done),
    .wr1_data_i  (shf_ent),
    .pop_i       (!fifo_empty),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Output register: head of queue for one cycle, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           out_q <= '0;
    else if (!fifo_empty) out_q <= head;
    else                  out_q <= '0;
  end

  assign out_resp = out_q.resp;
  assign out_data = out_q.data;
  assign out_tag  = out_q.tag;

  rate_within_capacity: assert property (@(posedge clk) disable iff (!reset) !fifo_full);

endmodule

// File: tb/tb_calc_core.sv
module tb_calc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd_in;
  logic [31:0] data_in;
  logic [1:0]  tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  always #5 clk = ~clk;

  calc_core dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_in   (cmd_in),
    .data_in  (data_in),
    .tag_in   (tag_in),
    .out_resp (out_resp),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completions scheduled by absolute edge number, queue drained one per edge.
  typedef struct {int e; bit shf; logic [1:0] r; logic [31:0] d; logic [1:0] t;} ev_t;
  typedef struct {logic [3:0] c; logic [31:0] d; logic [1:0] t;} stim_t;

  ev_t   pend[$];
  ev_t   outq[$];
  stim_t s[$];
  int    cyc, sh_load, sh_done;
  bit    op2_pend;
  logic [3:0]  h_cmd;
  logic [31:0] h_op1;
  logic [1:0]  h_tag;
  logic [1:0]  exp_r;
  logic [31:0] exp_d;
  logic [1:0]  exp_t;

  function automatic void model_clear();
    pend.delete();
    outq.delete();
    op2_pend = 1'b0;
    sh_load  = -100;
    sh_done  = -100;
    cyc      = 0;
  endfunction

  function automatic void sched(int e, bit shf, logic [1:0] r, logic [31:0] d, logic [1:0] t);
    ev_t v;
    v.e = e; v.shf = shf; v.r = r; v.d = d; v.t = t;
    pend.push_back(v);
  endfunction

  function automatic void dispatch(logic [31:0] op2);
    int x = cyc + 1;
    int amt = int'(op2[4:0]);
    logic [32:0] wide;
    case (h_cmd)
      4'd1: begin
        wide = {1'b0, h_op1} + {1'b0, op2};
        sched(x, 1'b0, wide[32] ? 2'd2 : 2'd1, wide[31:0], h_tag);
      end
      4'd2: sched(x, 1'b0, (op2 > h_op1) ? 2'd2 : 2'd1, h_op1 - op2, h_tag);
      4'd5, 4'd6: begin
        if (sh_load < x && x <= sh_done) begin
          sched(x, 1'b0, 2'd3, 32'd0, h_tag);
        end else begin
          sh_load = x;
          sh_done = x + amt + 1;
          sched(sh_done, 1'b1, 2'd1, (h_cmd == 4'd5) ? (h_op1 << amt) : (h_op1 >> amt), h_tag);
        end
      end
      default: sched(x, 1'b0, 2'd3, 32'd0, h_tag);
    endcase
  endfunction

  function automatic void model_edge(logic [3:0] c, logic [31:0] d, logic [1:0] t);
    ev_t keep[$];
    cyc++;
    if (op2_pend) begin
      op2_pend = 1'b0;
      dispatch(d);
    end else if (c != 4'd0) begin
      op2_pend = 1'b1;
      h_cmd = c; h_op1 = d; h_tag = t;
    end
    if (outq.size() > 0) begin
      ev_t h = outq.pop_front();
      exp_r = h.r; exp_d = h.d; exp_t = h.t;
    end else begin
      exp_r = 2'd0; exp_d = 32'd0; exp_t = 2'd0;
    end
    foreach (pend[i]) if (pend[i].e == cyc && !pend[i].shf) outq.push_back(pend[i]);
    foreach (pend[i]) if (pend[i].e == cyc && pend[i].shf)  outq.push_back(pend[i]);
    foreach (pend[i]) if (pend[i].e != cyc) keep.push_back(pend[i]);
    pend = keep;
  endfunction

  // Drive one cycle (called at a negedge), advance the model, return at the next negedge.
  task automatic tick(input logic [3:0] c, input logic [31:0] d, input logic [1:0] t, input logic rn);
    reset = rn; cmd_in = c; data_in = d; tag_in = t;
    if (!rn) begin
      model_clear();
      exp_r = 2'd0; exp_d = 32'd0; exp_t = 2'd0;
    end else begin
      model_edge(c, d, t);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void st(logic [3:0] c, logic [31:0] d, logic [1:0] t);
    stim_t v;
    v.c = c; v.d = d; v.t = t;
    s.push_back(v);
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) st(4'd0, 32'd0, 2'd0);
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(4'd1, 32'h1234, 2'd3, 1'b0);
      checks++;
      if (out_resp !== 2'd0 || out_data !== 32'd0 || out_tag !== 2'd0) begin
        errors++;
        $display("FAIL reset k=%0d: got %0d/%h/%0d want 0/0/0", k, out_resp, out_data, out_tag);
      end
    end
    tick(4'd0, 32'd0, 2'd0, 1'b1);
    checks++;
    if (out_resp !== 2'd0 || out_data !== 32'd0 || out_tag !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: got %0d/%h/%0d want 0/0/0", out_resp, out_data, out_tag);
    end
  endtask

  task automatic test_add();
    s.delete();
    st(4'd1, 32'd5, 2'd2); st(4'd0, 32'd7, 2'd0); idle(6);
    for (int k = 0; k < s.size(); k++) begin
      tick(s[k].c, s[k].d, s[k].t, 1'b1);
      checks++;
      if (out_resp !== exp_r || out_data !== exp_d || out_tag !== exp_t) begin
        errors++;
        $display("FAIL add k=%0d: got %0d/%h/%0d want %0d/%h/%0d", k, out_resp, out_data, out_tag, exp_r, exp_d, exp_t);
      end
      if (k == 3) begin
        checks++;
        if (out_resp !== 2'd1 || out_data !== 32'd12 || out_tag !== 2'd2) begin
          errors++;
          $display("FAIL add_T3: got %0d/%h/%0d want 1/c/2", out_resp, out_data, out_tag);
        end
      end
    end
  endtask

  task automatic test_overflow();
    s.delete();
    st(4'd1, 32'hFFFF_FFFF, 2'd1); st(4'd0, 32'd1, 2'd0);
    st(4'd2, 32'd3, 2'd0);         st(4'd0, 32'd5, 2'd0); idle(6);
    for (int k = 0; k < s.size(); k++) begin
      tick(s[k].c, s[k].d, s[k].t, 1'b1);
      checks++;
      if (out_resp !== exp_r || out_data !== exp_d || out_tag !== exp_t) begin
        errors++;
        $display("FAIL ovf k=%0d: got %0d/%h/%0d want %0d/%h/%0d", k, out_resp, out_data, out_tag, exp_r, exp_d, exp_t);
      end
      if (k == 3 && (out_resp !== 2'd2 || out_data !== 32'd0 || out_tag !== 2'd1)) begin
        errors++;
        $display("FAIL add_carry: got %0d/%h/%0d want 2/0/1", out_resp, out_data, out_tag);
      end
      if (k == 5 && (out_resp !== 2'd2 || out_data !== 32'hFFFF_FFFE || out_tag !== 2'd0)) begin
        errors++;
        $display("FAIL sub_borrow: got %0d/%h/%0d want 2/fffffffe/0", out_resp, out_data, out_tag);
      end
      if (k == 3 || k == 5) checks++;
    end
  endtask

  task automatic test_reorder();
    s.delete();
    st(4'd5, 32'd1, 2'd0); st(4'd0, 32'd4, 2'd0);
    st(4'd1, 32'd2, 2'd1); st(4'd0, 32'd2, 2'd0); idle(7);
    for (int k = 0; k < s.size(); k++) begin
      tick(s[k].c, s[k].d, s[k].t, 1'b1);
      checks++;
      if (out_resp !== exp_r || out_data !== exp_d || out_tag !== exp_t) begin
        errors++;
        $display("FAIL reorder k=%0d: got %0d/%h/%0d want %0d/%h/%0d", k, out_resp, out_data, out_tag, exp_r, exp_d, exp_t);
      end
      if (k == 5 && (out_resp !== 2'd1 || out_data !== 32'd4 || out_tag !== 2'd1)) begin
        errors++;
        $display("FAIL reorder_add_T5: got %0d/%h/%0d want 1/4/1", out_resp, out_data, out_tag);
      end
      if (k == 8 && (out_resp !== 2'd1 || out_data !== 32'd16 || out_tag !== 2'd0)) begin
        errors++;
        $display("FAIL reorder_shl_T8: got %0d/%h/%0d want 1/10/0", out_resp, out_data, out_tag);
      end
      if (k == 5 || k == 8) checks++;
    end
  endtask

  task automatic test_busy_invalid();
    s.delete();
    st(4'd6, 32'h8000_0000, 2'd0); st(4'd0, 32'd31, 2'd0);
    st(4'd5, 32'd3, 2'd1);         st(4'd0, 32'd1, 2'd0); idle(34);
    st(4'd9, 32'd123, 2'd3);       st(4'd0, 32'd5, 2'd0); idle(4);
    for (int k = 0; k < s.size(); k++) begin
      tick(s[k].c, s[k].d, s[k].t, 1'b1);
      checks++;
      if (out_resp !== exp_r || out_data !== exp_d || out_tag !== exp_t) begin
        errors++;
        $display("FAIL busy k=%0d: got %0d/%h/%0d want %0d/%h/%0d", k, out_resp, out_data, out_tag, exp_r, exp_d, exp_t);
      end
      if (k == 5 && (out_resp !== 2'd3 || out_data !== 32'd0 || out_tag !== 2'd1)) begin
        errors++;
        $display("FAIL busy_shl: got %0d/%h/%0d want 3/0/1", out_resp, out_data, out_tag);
      end
      if (k == 35 && (out_resp !== 2'd1 || out_data !== 32'd1 || out_tag !== 2'd0)) begin
        errors++;
        $display("FAIL shr31: got %0d/%h/%0d want 1/1/0", out_resp, out_data, out_tag);
      end
      if (k == 41 && (out_resp !== 2'd3 || out_data !== 32'd0 || out_tag !== 2'd3)) begin
        errors++;
        $display("FAIL invalid_cmd: got %0d/%h/%0d want 3/0/3", out_resp, out_data, out_tag);
      end
      if (k == 5 || k == 35 || k == 41) checks++;
    end
  endtask

  task automatic test_collision_reset();
    s.delete();
    st(4'd5, 32'd3, 2'd0);  st(4'd0, 32'd2, 2'd0); idle(1);
    st(4'd1, 32'd10, 2'd1); st(4'd0, 32'd20, 2'd0); idle(5);
    for (int k = 0; k < s.size(); k++) begin
      tick(s[k].c, s[k].d, s[k].t, 1'b1);
      checks++;
      if (out_resp !== exp_r || out_data !== exp_d || out_tag !== exp_t) begin
        errors++;
        $display("FAIL collide k=%0d: got %0d/%h/%0d want %0d/%h/%0d", k, out_resp, out_data, out_tag, exp_r, exp_d, exp_t);
      end
      if (k == 6 && (out_resp !== 2'd1 || out_data !== 32'd30 || out_tag !== 2'd1)) begin
        errors++;
        $display("FAIL collide_add_first: got %0d/%h/%0d want 1/1e/1", out_resp, out_data, out_tag);
      end
      if (k == 7 && (out_resp !== 2'd1 || out_data !== 32'd12 || out_tag !== 2'd0)) begin
        errors++;
        $display("FAIL collide_shl_second: got %0d/%h/%0d want 1/c/0", out_resp, out_data, out_tag);
      end
      if (k == 6 || k == 7) checks++;
    end
    // Long shift plus an add in flight, then reset mid-operation.
    tick(4'd5, 32'd1, 2'd2, 1'b1);
    tick(4'd0, 32'd20, 2'd0, 1'b1);
    tick(4'd1, 32'd1, 2'd1, 1'b1);
    tick(4'd0, 32'd1, 2'd0, 1'b1);
    for (int k = 0; k < 2; k++) tick(4'd0, 32'd0, 2'd0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      tick(4'd0, 32'd0, 2'd0, 1'b1);
      checks++;
      if (out_resp !== 2'd0 || out_data !== 32'd0 || out_tag !== 2'd0) begin
        errors++;
        $display("FAIL after_midreset k=%0d: got %0d/%h/%0d want 0/0/0", k, out_resp, out_data, out_tag);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b;
    int r;
    s.delete();
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      c = 4'd1;
      else if (r < 5) c = 4'd2;
      else if (r < 7) c = 4'd5;
      else if (r < 9) c = 4'd6;
      else begin
        c = 4'($urandom_range(3, 15));
        if (c == 4'd5 || c == 4'd6) c = 4'd15;
      end
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      b = $urandom;
      if ((c == 4'd5 || c == 4'd6) && $urandom_range(0, 1) == 0) b = b & 32'hFFFF_FF03;
      st(c, a, 2'($urandom_range(0, 3)));
      st(4'($urandom_range(0, 15)), b, 2'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 3)));
    end
    idle(40);
    for (int k = 0; k < s.size(); k++) begin
      tick(s[k].c, s[k].d, s[k].t, 1'b1);
      checks++;
      if (out_resp !== exp_r || out_data !== exp_d || out_tag !== exp_t) begin
        errors++;
        $display("FAIL random k=%0d: got %0d/%h/%0d want %0d/%h/%0d", k, out_resp, out_data, out_tag, exp_r, exp_d, exp_t);
      end
    end
  endtask

  initial begin
    reset = 1'b0; cmd_in = '0; data_in = '0; tag_in = '0;
    model_clear();
    exp_r = 2'd0; exp_d = 32'd0; exp_t = 2'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_overflow();
    test_reorder();
    test_busy_invalid();
    test_collision_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
